// File: rtl/hazard_scoreboard.sv
// Interlock unit for the pipelined MIPS core: per-register countdown scoreboard
// of in-flight writes, stall/bubble/flush generation and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 7,
    parameter int LW      = 3,
    parameter int CW      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_rd,
    input  logic [LW-1:0]   id_lat,
    input  logic            id_jump,
    input  logic            ex_branch_taken,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic [NREG-1:0] busy_mask,
    output logic [CW-1:0]   stall_cnt
);

    localparam logic [LW-1:0] LAT_CAP = LW'(MAX_LAT);

    logic [LW-1:0] r_cnt [NREG];
    logic [CW-1:0] r_stall_cnt;

    logic          w_busy_rs;
    logic          w_busy_rt;
    logic          w_data_stall;
    logic          w_issue;
    logic [LW-1:0] w_lat_sat;

    always_comb begin
        w_busy_rs    = (id_rs != '0) && (r_cnt[id_rs] != '0);
        w_busy_rt    = (id_rt != '0) && (r_cnt[id_rt] != '0);
        w_data_stall = id_valid && ((id_use_rs && w_busy_rs) || (id_use_rt && w_busy_rt));
        w_issue      = id_valid && !w_data_stall && !ex_branch_taken;
        w_lat_sat    = (id_lat > LAT_CAP) ? LAT_CAP : id_lat;
    end

    // A taken branch outranks a data stall: the stalled instruction is killed anyway.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst) begin
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_data_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_valid && id_jump) begin
                ifid_flush  = 1'b1;
            end
        end
    end

    // Entry 0 is only ever written by reset, so r0 never reads busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_issue && id_wr_en && (id_lat != '0) && (id_rd == AW'(r))) begin
                    r_cnt[r] <= w_lat_sat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - LW'(1);
                end
            end
            if (w_data_stall && !ex_branch_taken && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy_mask[i] = (r_cnt[i] != '0);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, multi-cycle corner sequences
// and random traffic against a ready-time reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_wr_en, id_jump, ex_branch_taken;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_lat;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble;
    logic [31:0] s_busy_mask;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_lat(id_lat), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CW(4)) u_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_lat(id_lat), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .busy_mask(s_busy_mask), .stall_cnt(s_stall_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: absolute cycle at which each register's result becomes forwardable.
    int cyc;
    int ready_at[32];
    int m_stalls;

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; bit wr; int rd; int lat; bit jmp; bit br;
        bit e_pc; bit e_fl; bit e_bub; logic [31:0] e_busy; int e_stall;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    function automatic bit m_stall();
        return id_valid && ((id_use_rs && m_busy(int'(id_rs))) || (id_use_rt && m_busy(int'(id_rt))));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        m_stalls = 0;
    endtask

    task automatic check_model();
        bit e_pc, e_fl, e_bub;
        logic [31:0] e_busy;
        int e_small;
        e_pc = 1; e_fl = 0; e_bub = 0;
        if (ex_branch_taken) begin e_fl = 1; e_bub = 1; end
        else if (m_stall()) begin e_pc = 0; e_bub = 1; end
        else if (id_valid && id_jump) e_fl = 1;
        for (int r = 0; r < 32; r++) e_busy[r] = m_busy(r);
        e_small = (m_stalls > 15) ? 15 : m_stalls;
        chk("pc_en", 64'(pc_en), 64'(e_pc));
        chk("ifid_en", 64'(ifid_en), 64'(e_pc));
        chk("ifid_flush", 64'(ifid_flush), 64'(e_fl));
        chk("idex_bubble", 64'(idex_bubble), 64'(e_bub));
        chk("busy_mask", 64'(busy_mask), 64'(e_busy));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls > 65535 ? 65535 : m_stalls));
        chk("stall_cnt_cw4", 64'(s_stall_cnt), 64'(e_small));
    endtask

    // Advance one clock: the model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        bit st, iss;
        int l;
        @(posedge clk);
        if (!rst) begin
            st  = m_stall();
            iss = id_valid && !st && !ex_branch_taken;
            l   = (int'(id_lat) > 7) ? 7 : int'(id_lat);
            if (iss && id_wr_en && id_rd != 0 && l != 0) ready_at[id_rd] = cyc + 1 + l;
            if (st && !ex_branch_taken) m_stalls++;
            cyc++;
        end
        #1;
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit wr, input int rd, input int lat, input bit jmp, input bit br);
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = wr; id_rd = rd[4:0]; id_lat = lat[2:0]; id_jump = jmp; ex_branch_taken = br;
    endtask

    function automatic vec_t mk(bit v, int rs, int rt, bit urs, bit urt, bit wr, int rd, int lat,
                                bit jmp, bit br, bit e_pc, bit e_fl, bit e_bub,
                                logic [31:0] e_busy, int e_stall);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.wr = wr; t.rd = rd;
        t.lat = lat; t.jmp = jmp; t.br = br; t.e_pc = e_pc; t.e_fl = e_fl; t.e_bub = e_bub;
        t.e_busy = e_busy; t.e_stall = e_stall;
        return t;
    endfunction

    initial begin
        //                 v rs rt urs urt wr rd lat jmp br  pc fl bub busy          stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0,   1, 0, 0, 32'h0,        0)); // load r8
        tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 32'h100,      0)); // load-use bubble
        tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0,        1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 4, 0, 0,   1, 0, 0, 32'h0,        1)); // mult r5
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 32'h20,       1));
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 32'h20,       2));
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 32'h20,       3));
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 32'h20,       4));
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0,        5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 7, 0, 0,   1, 0, 0, 32'h0,        5)); // write r0
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 3, 0, 0, 0,   1, 0, 0, 32'h0,        5)); // lat 0
        tbl.push_back(mk(1, 3, 0, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0,        5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 3, 0, 0,   1, 0, 0, 32'h0,        5));
        tbl.push_back(mk(1, 9, 0, 1, 0, 1, 10, 5, 0, 1,  1, 1, 1, 32'h200,      5)); // branch over stall
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h200,      5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h200,      5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0,        5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 31, 2, 1, 0,  1, 1, 0, 32'h0,        5)); // jal-like
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h80000000, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h80000000, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0,        5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 3, 0, 0,   1, 0, 0, 32'h0,        5)); // WAW reload
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0,   1, 0, 0, 32'h10,       5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h10,       5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0,        5));

        cyc = 0;
        model_reset();
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #2;
        chk("reset pc_en", 64'(pc_en), 64'(1));
        chk("reset ifid_en", 64'(ifid_en), 64'(1));
        chk("reset ifid_flush", 64'(ifid_flush), 64'(0));
        chk("reset idex_bubble", 64'(idex_bubble), 64'(0));
        chk("reset busy_mask", 64'(busy_mask), 64'(0));
        chk("reset stall_cnt", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wr,
                   tbl[i].rd, tbl[i].lat, tbl[i].jmp, tbl[i].br);
            #2;
            chk($sformatf("vec%0d pc_en", i), 64'(pc_en), 64'(tbl[i].e_pc));
            chk($sformatf("vec%0d ifid_en", i), 64'(ifid_en), 64'(tbl[i].e_pc));
            chk($sformatf("vec%0d ifid_flush", i), 64'(ifid_flush), 64'(tbl[i].e_fl));
            chk($sformatf("vec%0d idex_bubble", i), 64'(idex_bubble), 64'(tbl[i].e_bub));
            chk($sformatf("vec%0d busy_mask", i), 64'(busy_mask), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_stall));
            check_model();
            tick();
        end

        // Three 7-cycle stalls push the 4-bit counter past its ceiling.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 0, 1, 2, 7, 0, 0);
            #2; check_model(); tick();
            for (int j = 0; j < 8; j++) begin
                set_in(1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
                #2; check_model(); tick();
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("sat cw4 stall_cnt", 64'(s_stall_cnt), 64'(15));
        chk("sat cw16 stall_cnt", 64'(stall_cnt), 64'(26));
        tick();

        // Reset asserted in the middle of a long stall.
        set_in(1, 0, 0, 0, 0, 1, 6, 7, 0, 0);
        #2; check_model(); tick();
        for (int j = 0; j < 2; j++) begin
            set_in(1, 6, 0, 1, 0, 0, 0, 0, 1, 0);
            #2; check_model(); tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst busy_mask", 64'(busy_mask), 64'(0));
        chk("midrst stall_cnt", 64'(stall_cnt), 64'(0));
        chk("midrst pc_en", 64'(pc_en), 64'(1));
        chk("midrst idex_bubble", 64'(idex_bubble), 64'(0));
        chk("midrst ifid_flush", 64'(ifid_flush), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst pc_en", 64'(pc_en), 64'(1));
        check_model();
        tick();

        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            set_in($urandom_range(0, 7) != 0,
                   (sel == 0) ? 31 : $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
                   (sel == 1) ? 31 : $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            #2; check_model(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised interlock unit for the pipelined MIPS core.
- Keeps a per-register countdown scoreboard of in-flight writes with variable result latency (load, multiply, multi-cycle ALU ops).
- Generates the stall, bubble and flush controls for the IF, IF/ID and ID/EX stages.
- Handles ID-stage jumps and EX-resolved taken branches, and keeps a saturating stall-cycle performance counter.
- Sits beside the decoder; opcode decode stays outside the block.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register index width; must satisfy 2^AW >= NREG.
- MAX_LAT, 7, largest supported producer latency in cycles; larger requests saturate to this value.
- LW, 3, countdown width; must satisfy 2^LW > MAX_LAT.
- CW, 16, stall performance counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  AW  source register 1.
- id_rt  in  AW  source register 2.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes id_rd.
- id_rd  in  AW  destination register.
- id_lat  in  LW  cycles until the result can be forwarded; 0 = forwardable immediately (plain ALU op).
- id_jump  in  1  ID instruction is an unconditional jump.
- ex_branch_taken  in  1  branch in EX resolved taken.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  insert NOP into ID/EX.
- busy_mask  out  NREG  bit r = cnt[r] != 0.
- stall_cnt  out  CW  saturating count of cycles in which data_stall was asserted.

Behaviour:
- State:
  - cnt[1..NREG-1], each LW bits. cnt[0] is constant 0.
  - stall_cnt, CW bits.
  - All of these are cleared asynchronously while rst = 1.
- data_stall (combinational) = id_valid & ((id_use_rs & id_rs != 0 & cnt[id_rs] != 0) | (id_use_rt & id_rt != 0 & cnt[id_rt] != 0)).
- Output priority, combinational:
  1. ex_branch_taken = 1:
     - ifid_flush = 1, idex_bubble = 1, pc_en = 1, ifid_en = 1.
     - data_stall is ignored in this cycle.
  2. else data_stall = 1:
     - pc_en = 0, ifid_en = 0, idex_bubble = 1, ifid_flush = 0.
  3. else id_valid & id_jump:
     - ifid_flush = 1, pc_en = 1, ifid_en = 1, idex_bubble = 0.
  4. else (default):
     - pc_en = 1, ifid_en = 1, ifid_flush = 0, idex_bubble = 0.
- Output values while rst = 1: pc_en = 1, ifid_en = 1, ifid_flush = 0, idex_bubble = 0, busy_mask = 0, stall_cnt = 0.
- issue = id_valid & !data_stall & !ex_branch_taken.
- Counter update, each clock edge, for every r != 0:
  - if issue & id_wr_en & id_rd == r & id_lat != 0: cnt[r] <= min(id_lat, MAX_LAT).
  - else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - A new issue to a register whose count is still nonzero (WAW) reloads the count; the new load wins over the decrement.
  - id_rd = 0, id_lat = 0, or a killed issue leaves the scoreboard untouched; counts simply keep decrementing.
- Latency convention:
  - A consumer entering ID k cycles after its producer issued (k = 1 for the adjacent instruction) stalls for max(0, L - k + 1) cycles.
  - Example: a load with L = 1 immediately followed by a dependent instruction gives exactly one bubble.
- A jump issues normally; only the wrong-path fetch in IF/ID is flushed.
- A taken branch kills both the ID instruction and the IF instruction.
- stall_cnt increments in each cycle with data_stall = 1 and ex_branch_taken = 0; it holds at all-ones once saturated.
- Reset mid-stall: all counts clear, so the stall releases on the first cycle after reset deasserts.

Test Plan:
- Load-use: issue id_rd = 8, id_lat = 1; next cycle the ID instruction uses rs = 8 -> exactly one cycle with pc_en = 0, ifid_en = 0, idex_bubble = 1; issues the cycle after; stall_cnt = 1.
- Long latency: issue rd = 5, lat = 4; next cycle the consumer uses rt = 5 -> 4 stall cycles; busy_mask[5] reads 1 for 4 cycles, then 0.
- Register zero and latency zero: issue rd = 0, lat = 7 and rd = 3, lat = 0 -> busy_mask stays 0; a following consumer of r0 or r3 sees no stall.
- Branch over stall: data_stall active and ex_branch_taken = 1 in the same cycle -> ifid_flush = 1, idex_bubble = 1, pc_en = 1; scoreboard gets no new entry; stall_cnt does not increment.
- Jump: id_jump = 1 with id_wr_en = 1, rd = 31, lat = 2 -> ifid_flush = 1 for one cycle; busy_mask[31] = 1 for 2 cycles.
- Saturation and reset: CW = 4 with a held stall -> stall_cnt stops at 15. Asserting rst mid-stall -> busy_mask = 0, stall_cnt = 0, pc_en = 1 immediately.
